// File: rtl/logic_pipe_if.sv
// Operand/result handshake bundle for logic_pipe_unit.
// Upstream (operand fetch) and downstream (writeback) share one bundle;
// the master side is whoever drives operands and consumes results.
interface logic_pipe_if #(
   parameter int WIDTH = 32
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       OP;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] R;
   logic             Z;
   logic             P;

   modport master (
      output IN_VALID, A, B, OP, OUT_READY,
      input  IN_READY, OUT_VALID, R, Z, P
   );

   modport slave (
      input  IN_VALID, A, B, OP, OUT_READY,
      output IN_READY, OUT_VALID, R, Z, P
   );
endinterface

// File: rtl/logic_pipe_unit.sv
// Pipelined bitwise logic unit: eight ops, zero/parity flags, elastic
// valid chain so empty stages fill while later stages are stalled.
module logic_pipe_unit #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic          CLK,
   input  logic          RST_N,
   logic_pipe_if.slave   bus
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOR  = 3'b011,
      OP_XNOR = 3'b100,
      OP_NAND = 3'b101,
      OP_ANDN = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic             z;
      logic             p;
   } pay_t;

   pay_t              pay [STAGES];
   pay_t              in_pay;
   logic [STAGES-1:0] vld_pipe;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] lo_mask;
   logic [WIDTH-1:0]  res;

   // Operation decode and flags, computed from the live operands so they
   // land in stage 0 together with the result.
   always_comb begin
      res = '0;
      unique case (op_e'(bus.OP))
         OP_AND:  res = bus.A & bus.B;
         OP_OR:   res = bus.A | bus.B;
         OP_XOR:  res = bus.A ^ bus.B;
         OP_NOR:  res = ~(bus.A | bus.B);
         OP_XNOR: res = ~(bus.A ^ bus.B);
         OP_NAND: res = ~(bus.A & bus.B);
         OP_ANDN: res = bus.A & ~bus.B;
         OP_PASS: res = bus.A;
         default: res = '0;
      endcase
      in_pay.r = res;
      in_pay.z = ~|res;
      in_pay.p = ^res;
   end

   // Stage i advances when it, or any stage after it, has a hole, or when
   // the output is being consumed. Written in closed form so the ready
   // chain has no self-referencing vector.
   always_comb begin
      adv     = '0;
      lo_mask = '0;
      for (int i = 0; i < STAGES; i++) begin
         lo_mask = ((STAGES)'(1) << i) - (STAGES)'(1);
         adv[i]  = bus.OUT_READY || ((vld_pipe | lo_mask) != '1);
      end
   end

   // Valid chain and payload shift. Payload only loads alongside a valid
   // bit, so the output stays at its reset value until the first result.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_pipe <= '0;
         for (int i = 0; i < STAGES; i++) pay[i] <= '0;
      end else begin
         if (adv[0]) begin
            vld_pipe[0] <= bus.IN_VALID;
            if (bus.IN_VALID) pay[0] <= in_pay;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               vld_pipe[i] <= vld_pipe[i-1];
               if (vld_pipe[i-1]) pay[i] <= pay[i-1];
            end
         end
      end
   end

   assign bus.IN_READY  = adv[0];
   assign bus.OUT_VALID = vld_pipe[STAGES-1];
   assign bus.R         = pay[STAGES-1].r;
   assign bus.Z         = pay[STAGES-1].z;
   assign bus.P         = pay[STAGES-1].p;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Bench for logic_pipe_unit: directed steps on a 32/2 instance, random
// traffic on 1/1 and 64/4 instances, all against a queue reference model.
module tb_logic_pipe_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv [3];
   logic        ordy [3];
   logic [63:0] a, b;
   logic [2:0]  op;

   always #5 clk = ~clk;

   logic_pipe_if #(.WIDTH(32)) b0 ();
   logic_pipe_if #(.WIDTH(1))  b1 ();
   logic_pipe_if #(.WIDTH(64)) b2 ();

   assign b0.IN_VALID = iv[0];  assign b0.OUT_READY = ordy[0];
   assign b0.A = a[31:0];       assign b0.B = b[31:0];        assign b0.OP = op;
   assign b1.IN_VALID = iv[1];  assign b1.OUT_READY = ordy[1];
   assign b1.A = a[0:0];        assign b1.B = b[0:0];         assign b1.OP = op;
   assign b2.IN_VALID = iv[2];  assign b2.OUT_READY = ordy[2];
   assign b2.A = a;             assign b2.B = b;              assign b2.OP = op;

   logic_pipe_unit #(.WIDTH(32), .STAGES(2)) u0 (.CLK(clk), .RST_N(rst_n), .bus(b0.slave));
   logic_pipe_unit #(.WIDTH(1),  .STAGES(1)) u1 (.CLK(clk), .RST_N(rst_n), .bus(b1.slave));
   logic_pipe_unit #(.WIDTH(64), .STAGES(4)) u2 (.CLK(clk), .RST_N(rst_n), .bus(b2.slave));

   logic [63:0] o_r [3];
   logic        o_v [3], o_z [3], o_p [3], o_rdy [3];
   assign o_r[0] = 64'(b0.R); assign o_v[0] = b0.OUT_VALID; assign o_z[0] = b0.Z; assign o_p[0] = b0.P; assign o_rdy[0] = b0.IN_READY;
   assign o_r[1] = 64'(b1.R); assign o_v[1] = b1.OUT_VALID; assign o_z[1] = b1.Z; assign o_p[1] = b1.P; assign o_rdy[1] = b1.IN_READY;
   assign o_r[2] = b2.R;      assign o_v[2] = b2.OUT_VALID; assign o_z[2] = b2.Z; assign o_p[2] = b2.P; assign o_rdy[2] = b2.IN_READY;

   typedef struct {
      logic [63:0] r;
      logic        z;
      logic        p;
      int          acc;
   } item_t;

   item_t       q [$];
   logic [63:0] cap [$];
   logic [1:0]  capf [$];
   int          edge_n = 0;
   int          n_pass = 0;
   int          n_tot  = 0;
   logic [31:0] tbl [8];

   function automatic int sw(int d);
      return (d == 0) ? 2 : (d == 1) ? 1 : 4;
   endfunction

   function automatic int ww(int d);
      return (d == 0) ? 32 : (d == 1) ? 1 : 64;
   endfunction

   function automatic logic [63:0] ref_r(logic [63:0] x, logic [63:0] y, logic [2:0] o, int w);
      logic [63:0] m, v;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      case (o)
         3'd0: v = x & y;
         3'd1: v = x | y;
         3'd2: v = x ^ y;
         3'd3: v = ~(x | y);
         3'd4: v = ~(x ^ y);
         3'd5: v = ~(x & y);
         3'd6: v = x & ~y;
         default: v = x;
      endcase
      return v & m;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle on DUT d: drive, check against the model, then step
   // the model by the transfers that happen at the next rising edge.
   task automatic cyc(int d, logic v, logic rd, logic [2:0] o, logic [63:0] ia, logic [63:0] ib);
      logic  vis, rdy, acc_in, acc_out;
      item_t it;
      iv[d] = v; ordy[d] = rd; op = o; a = ia; b = ib;
      #1;
      vis = (q.size() > 0) && (edge_n - q[0].acc >= sw(d) - 1);
      rdy = (q.size() < sw(d)) || rd;
      chk("out_valid", 64'(o_v[d]), 64'(vis));
      chk("in_ready", 64'(o_rdy[d]), 64'(rdy));
      if (vis) begin
         chk("r", o_r[d], q[0].r);
         chk("z", 64'(o_z[d]), 64'(q[0].z));
         chk("p", 64'(o_p[d]), 64'(q[0].p));
         if (rd) begin
            cap.push_back(o_r[d]);
            capf.push_back({o_z[d], o_p[d]});
         end
      end
      acc_in  = v && rdy;
      acc_out = vis && rd;
      it.r = ref_r(ia, ib, o, ww(d));
      it.z = (it.r == 64'd0);
      it.p = ^it.r;
      it.acc = 0;
      @(posedge clk);
      edge_n++;
      if (acc_out) void'(q.pop_front());
      if (acc_in) begin
         it.acc = edge_n;
         q.push_back(it);
      end
      @(negedge clk);
   endtask

   task automatic drain(int d);
      int guard = 0;
      while (q.size() > 0 && guard < 50) begin
         cyc(d, 1'b0, 1'b1, 3'd0, 64'd0, 64'd0);
         guard++;
      end
      chk("drain_left", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'hFF00_EDCB, 32'h000F_0000,
              32'h00FF_1234, 32'hFF0F_EDCB, 32'hF000_0000, 32'hF0F0_1234};
      for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
      a = '0; b = '0; op = '0;

      // reset state
      #3;
      chk("rst_out_valid", 64'(o_v[0]), 64'd0);
      chk("rst_r", o_r[0], 64'd0);
      chk("rst_z", 64'(o_z[0]), 64'd0);
      chk("rst_p", 64'(o_p[0]), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // all eight ops back to back
      cap.delete(); capf.delete();
      for (int i = 0; i < 8; i++) cyc(0, 1'b1, 1'b1, 3'(i), 64'hF0F0_1234, 64'h0FF0_FFFF);
      drain(0);
      chk("op_count", 64'(cap.size()), 64'd8);
      if (cap.size() == 8)
         for (int i = 0; i < 8; i++) chk("op_table", cap[i], 64'(tbl[i]));

      // flags
      cap.delete(); capf.delete();
      cyc(0, 1'b1, 1'b1, 3'd2, 64'h1234_5678, 64'h1234_5678);
      cyc(0, 1'b1, 1'b1, 3'd1, 64'h7, 64'h0);
      drain(0);
      chk("flag_count", 64'(cap.size()), 64'd2);
      if (cap.size() == 2) begin
         chk("flag_r0", cap[0], 64'd0);
         chk("flag_zp0", 64'(capf[0]), 64'b10);
         chk("flag_r1", cap[1], 64'd7);
         chk("flag_zp1", 64'(capf[1]), 64'b01);
      end

      // backpressure: only two accepted while stalled, then drain with input running
      for (int i = 0; i < 5; i++) cyc(0, 1'b1, 1'b0, 3'(i), {32'd0, $urandom}, {32'd0, $urandom});
      chk("bp_inflight", 64'(q.size()), 64'd2);
      for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b1, 3'(i), {32'd0, $urandom}, {32'd0, $urandom});
      drain(0);

      // bubble collapse
      cyc(0, 1'b1, 1'b0, 3'd7, 64'hAAAA_5555, 64'd0);
      cyc(0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      cyc(0, 1'b1, 1'b0, 3'd7, 64'h1357_9BDF, 64'd0);
      chk("bubble_inflight", 64'(q.size()), 64'd2);
      drain(0);

      // asynchronous reset with two items in flight
      cyc(0, 1'b1, 1'b0, 3'd7, 64'hDEAD_BEEF, 64'd0);
      cyc(0, 1'b1, 1'b0, 3'd1, 64'h0000_0F00, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(o_v[0]), 64'd0);
      chk("arst_r", o_r[0], 64'd0);
      chk("arst_z", 64'(o_z[0]), 64'd0);
      chk("arst_p", 64'(o_p[0]), 64'd0);
      q.delete();
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1, 3'd0, 64'd0, 64'd0);

      // random traffic on every instance
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 300; i++)
            cyc(d, 1'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom});
         drain(d);
         iv[d] = 1'b0; ordy[d] = 1'b1;
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/logic_pipe_unit.md
Name: logic_pipe_unit

Overview:
- Parametrised, pipelined bitwise logic unit for the 32-bit ALU datapath.
- Generalises the fixed 32-bit XOR slice to any operand width and eight selectable bitwise operations.
- Adds zero and parity flags and a ready/valid handshake, so it can sit between the operand-fetch and writeback stages under backpressure.

Parameters:
WIDTH, 32, operand/result width in bits (>=1)
STAGES, 2, pipeline depth in register stages (1..4); fixed accept-to-output latency

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
IN_VALID  input  1  operands and opcode valid this cycle
IN_READY  output  1  unit accepts a transaction this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OP  input  3  operation select (encoding below)
OUT_VALID  output  1  R/Z/P hold a valid result
OUT_READY  input  1  downstream consumes result this cycle
R  output  WIDTH  result
Z  output  1  1 when R == 0
P  output  1  XOR-reduction (odd parity) of R

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (CLK, RST_N).
- OP encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 XNOR
  - 101 NAND
  - 110 ANDN (A & ~B)
  - 111 PASS (R = A)
  - All codes are legal; no error output.
- Handshake:
  - Input transfer occurs when IN_VALID && IN_READY.
  - Output transfer occurs when OUT_VALID && OUT_READY.
  - A, B and OP are sampled only on an input transfer.
- Stage 0 registers the computed result with Z and P, all derived from the sampled operands in the same cycle. Stages 1..STAGES-1 move the payload unchanged.
- Per-stage valid bit v[i]. Stage i advances (loads from stage i-1 or from the input) when !v[i] or stage i+1 advances. The last stage advances on OUT_READY.
- IN_READY = !v[0] || stage 0 advances. This is combinational from OUT_READY through the valid chain, with no combinational path from A/B/OP/IN_VALID.
- Bubbles collapse: an empty stage fills even while a later stage is stalled.
- Latency: a transaction accepted at edge k appears on OUT_VALID/R after edge k+STAGES-1. OUT_VALID is visible in the cycle following edge k+STAGES-1, i.e. STAGES cycles after the accept cycle.
- Throughput: 1 transaction per cycle while OUT_READY=1.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Stall: while OUT_VALID && !OUT_READY, R/Z/P/OUT_VALID hold stable. At most STAGES transactions are in flight. When all stages are full and OUT_READY=0, IN_READY=0.
- Simultaneous accept and emit on a full pipe with OUT_READY=1: IN_READY=1, every stage shifts, occupancy is unchanged.
- Reset (any time, including mid-stream):
  - All v[i]=0, OUT_VALID=0, R=0, Z=0, P=0.
  - In-flight transactions are discarded.
  - IN_READY=1 from the first cycle after reset deassertion.
- Payload registers of invalid stages may hold stale data. Outputs R/Z/P are only meaningful when OUT_VALID=1, except that they read 0 after reset until the first result.
- Width rules: all operations are bitwise on WIDTH bits, with no carry and no sign extension. Z and P are computed on the full WIDTH-bit result.
- STAGES=1: single register stage, latency 1, IN_READY = !OUT_VALID || OUT_READY.

Test Plan:
- WIDTH=32, STAGES=2, OUT_READY=1; A=0xF0F0_1234, B=0x0FF0_FFFF, OP cycled 000..111 back-to-back:
  - Results in order: 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, 0x00FF_1234, 0xFF0F_EDCB, 0xF000_0000, 0xF0F0_1234.
  - Each result appears 2 cycles after its accept; OUT_VALID stays high 8 consecutive cycles.
- Flags: A=B=0x1234_5678 with OP=010 -> R=0, Z=1, P=0. A=0x0000_0007, B=0, OP=001 -> R=7, Z=0, P=1.
- Backpressure: hold OUT_READY=0 and drive IN_VALID=1 continuously:
  - Exactly 2 transfers are accepted, then IN_READY=0, and R holds the first result stable.
  - Raise OUT_READY -> results drain in order, one per cycle, with the input resuming the same cycle.
- Bubble collapse: accept one item, stall output, idle 1 cycle, then offer a second item -> accepted the same cycle (stage 0 empty); both delivered in order after OUT_READY rises.
- Reset mid-stream: assert RST_N=0 asynchronously (off clock edge) with 2 items in flight:
  - OUT_VALID, R, Z and P go to 0 immediately; nothing is emitted afterwards.
  - IN_READY=1 on the first cycle after release.
- Parameter sweep: WIDTH=1/STAGES=1 and WIDTH=64/STAGES=4 with random stimulus and random OUT_READY, checked against a scoreboard model for correct values, order, latency and stall stability.
